// File: rtl/jam_cost_arbiter.sv
// rtl/jam_cost_arbiter.sv - burst-locked round-robin arbiter for the shared cost-table read port
// Optional feature macro: JAM_ARB_FIXED_PRIO_EN (lowest-index requester always wins in S_IDLE)
module jam_cost_arbiter #(
    parameter int NREQ  = 4,
    parameter int BURST = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic [3*NREQ-1:0] REQ_W,
    input  logic [3*NREQ-1:0] REQ_J,
    output logic [NREQ-1:0]   GNT,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [6:0]        Cost,
    output logic [6:0]        RD_COST,
    output logic [NREQ-1:0]   RD_VLD,
    output logic [2:0]        RD_IDX,
    output logic              BUSY
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]   r_owner;
    logic [2:0]      r_beat;
    logic [6:0]      r_rd_cost;
    logic [NREQ-1:0] r_rd_vld;
    logic [2:0]      r_rd_idx;

    logic [IW-1:0]   w_winner;
    logic            w_any_req;
    logic            w_owner_req;
    logic            w_beat_fire;
    logic            w_last_beat;

    assign w_any_req   = |REQ;
    assign w_owner_req = REQ[r_owner];
    assign w_beat_fire = (r_state == S_BUSY) && w_owner_req;
    assign w_last_beat = (r_beat == 3'(BURST - 1));

`ifdef JAM_ARB_FIXED_PRIO_EN
    // Downward scan so the lowest set index is the last assignment to stick.
    always_comb begin
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                w_winner = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] r_ptr;
    logic          w_found;
    int            w_idx;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(r_ptr) + i) % NREQ;
            if (!w_found && REQ[w_idx]) begin
                w_winner = IW'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_ptr <= IW'((int'(w_winner) + 1) % NREQ);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!w_owner_req || w_last_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address mux is zeroed whenever no beat is in progress, including early release.
    always_comb begin
        BUSY = (r_state == S_BUSY);
        W    = 3'd0;
        J    = 3'd0;
        if (w_beat_fire) begin
            W = REQ_W[3*int'(r_owner) +: 3];
            J = REQ_J[3*int'(r_owner) +: 3];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_gnt     <= '0;
            r_owner   <= '0;
            r_beat    <= 3'd0;
            r_rd_cost <= 7'd0;
            r_rd_vld  <= '0;
            r_rd_idx  <= 3'd0;
        end else begin
            r_rd_vld <= '0;
            if (r_state == S_IDLE) begin
                if (w_any_req) begin
                    r_gnt           <= '0;
                    r_gnt[w_winner] <= 1'b1;
                    r_owner         <= w_winner;
                    r_beat          <= 3'd0;
                end
            end else if (w_beat_fire) begin
                r_rd_cost <= Cost;
                r_rd_idx  <= r_beat;
                r_rd_vld  <= r_gnt;
                r_beat    <= r_beat + 3'd1;
                if (w_last_beat) begin
                    r_gnt <= '0;
                end
            end else begin
                r_gnt <= '0;
            end
        end
    end

    assign GNT     = r_gnt;
    assign RD_COST = r_rd_cost;
    assign RD_VLD  = r_rd_vld;
    assign RD_IDX  = r_rd_idx;

endmodule
